ov7670_config_sequencer: RTL and testbench

OV7670_CONFIG_SEQUENCER -- requirements
Module: ov7670_config_sequencer

---
 rtl/ov7670_config_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer.sv
// OV7670 startup configuration sequencer.
//
// Walks a startup ROM of {register, value} commands and issues one SCCB write per entry.
// The entry 16'hFFF0 inserts a DELAY_CYCLES pause, and the entry 16'hFFFF ends the list.
//
// Optional feature: define OV7670_SEQ_TIMEOUT_EN to enable the SCCB acknowledge watchdog.
// Without it, WAIT_ACK waits indefinitely and error is tied low.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         single-cycle request to run the full command list
//   rom_cmd       current ROM command: [15:8] register, [7:0] value
//   rom_inc       single-cycle pulse that advances the ROM address
//   rom_rst_n     active-low ROM address rewind (held low in IDLE and DONE)
//   sccb_ready    SCCB master idle and able to accept a write
//   sccb_start    single-cycle write request to the SCCB master
//   sccb_id       device ID (constant CAM_ID)
//   sccb_addr     register address of the current write
//   sccb_data     value of the current write
//   busy          sequence in progress
//   done          list completed; held until the next start
//   error         watchdog abort; held until the next start
module ov7670_config_sequencer #(
  parameter int unsigned DELAY_CYCLES   = 250000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  CAM_ID         = 8'h42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] rom_cmd,
  output logic        rom_inc,
  output logic        rom_rst_n,
  input  logic        sccb_ready,
  output logic        sccb_start,
  output logic [7:0]  sccb_id,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned MaxCycles = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES
                                                                       : TIMEOUT_CYCLES;
  // One spare bit so the counter can never wrap before its terminal compare.
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] DelayLast   = CntW'(DELAY_CYCLES - 1);
  localparam logic [CntW-1:0] RomWaitLast = CntW'(1);

  localparam logic [15:0] CmdEnd   = 16'hFFFF;
  localparam logic [15:0] CmdDelay = 16'hFFF0;

  typedef enum logic [2:0] {
    StIdle,
    StRomWait,
    StFetch,
    StSend,
    StWaitAck,
    StDelay,
    StAdvance,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            start_q, start_d;
  logic            done_q, done_d;

`ifdef OV7670_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  logic error_q, error_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    start_d = 1'b0;
    done_d  = done_q;
`ifdef OV7670_SEQ_TIMEOUT_EN
    error_d = error_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          done_d  = 1'b0;
`ifdef OV7670_SEQ_TIMEOUT_EN
          error_d = 1'b0;
`endif
          cnt_d   = '0;
          state_d = StRomWait;
        end
      end
      // Two cycles: ROM address register, then ROM command register.
      StRomWait: begin
        if (cnt_q == RomWaitLast) begin
          cnt_d   = '0;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFetch: begin
        cnt_d = '0;
        if (rom_cmd == CmdEnd) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else if (rom_cmd == CmdDelay) begin
          state_d = StDelay;
        end else begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (sccb_ready) begin
          start_d = 1'b1;
          addr_d  = rom_cmd[15:8];
          data_d  = rom_cmd[7:0];
          cnt_d   = '0;
          state_d = StWaitAck;
        end
      end
      // The first WAIT_ACK cycle carries the start pulse; the master has not yet dropped
      // ready, so ready is only honoured once the pulse is gone.
      StWaitAck: begin
        if (!start_q && sccb_ready) begin
          cnt_d   = '0;
          state_d = StAdvance;
        end else begin
`ifdef OV7670_SEQ_TIMEOUT_EN
          if (cnt_q == TimeoutLast) begin
            cnt_d   = '0;
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      StDelay: begin
        if (cnt_q == DelayLast) begin
          cnt_d   = '0;
          state_d = StAdvance;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAdvance: begin
        cnt_d   = '0;
        state_d = StRomWait;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

`ifdef OV7670_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Decoded from the state register so that reset forces them low at once.
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign rom_rst_n  = busy;
  assign rom_inc    = (state_q == StAdvance);
  assign done       = done_q;
  assign sccb_start = start_q;
  assign sccb_id    = CAM_ID;
  assign sccb_addr  = addr_q;
  assign sccb_data  = data_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Testbench for ov7670_config_sequencer: ROM model {1280, FFF0, 1204, FFFF}, an SCCB
// master model with programmable acknowledge latency, and directed scenarios.
module tb_ov7670_config_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] rom_cmd;
  logic        rom_inc;
  logic        rom_rst_n;
  logic        sccb_ready;
  logic        sccb_start;
  logic [7:0]  sccb_id;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_data;
  logic        busy;
  logic        done;
  logic        error;

  ov7670_config_sequencer #(
    .DELAY_CYCLES  (10),
    .TIMEOUT_CYCLES(100),
    .CAM_ID        (8'h42)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom_cmd   (rom_cmd),
    .rom_inc   (rom_inc),
    .rom_rst_n (rom_rst_n),
    .sccb_ready(sccb_ready),
    .sccb_start(sccb_start),
    .sccb_id   (sccb_id),
    .sccb_addr (sccb_addr),
    .sccb_data (sccb_data),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // ROM model: registered address, registered command output.
  logic [1:0] rom_addr = 2'd0;
  int         rom_over = 0;

  function automatic logic [15:0] rom_at(input logic [1:0] a);
    case (a)
      2'd0:    return 16'h1280;
      2'd1:    return 16'hFFF0;
      2'd2:    return 16'h1204;
      default: return 16'hFFFF;
    endcase
  endfunction

  initial rom_cmd = 16'h0000;

  always @(posedge clk) begin
    if (!rom_rst_n) begin
      rom_addr <= 2'd0;
    end else if (rom_inc) begin
      if (rom_addr == 2'd3) rom_over <= rom_over + 1;
      else rom_addr <= rom_addr + 2'd1;
    end
    rom_cmd <= rom_at(rom_addr);
  end

  // SCCB master model and monitors, all sampled on the falling edge.
  logic        ready_m = 1'b1;
  logic        hold = 1'b0;
  int          ack_lat = 3;
  int          ack_cnt = 0;
  logic        in_write = 1'b0;
  logic [7:0]  w_addr = 8'h00;
  logic [7:0]  w_data = 8'h00;
  logic [23:0] wr_log [64];
  int          wr_n = 0;
  int          inc_cyc [64];
  int          inc_n = 0;
  int          cyc_n = 0;
  int          stab_err = 0;
  int          proto_err = 0;

  assign sccb_ready = ready_m & ~hold;

  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rst) begin
      ready_m  <= 1'b1;
      ack_cnt  <= 0;
      in_write <= 1'b0;
    end else begin
      if (sccb_start) begin
        if (sccb_ready) begin
          ready_m  <= 1'b0;
          ack_cnt  <= ack_lat;
          in_write <= 1'b1;
          w_addr   <= sccb_addr;
          w_data   <= sccb_data;
          if (wr_n < 64) wr_log[wr_n] <= {sccb_id, sccb_addr, sccb_data};
          wr_n     <= wr_n + 1;
        end else begin
          proto_err <= proto_err + 1;
        end
      end else if (!ready_m) begin
        if (ack_cnt <= 1) begin
          ready_m  <= 1'b1;
          in_write <= 1'b0;
        end else begin
          ack_cnt <= ack_cnt - 1;
        end
      end
      if (in_write && (sccb_addr != w_addr || sccb_data != w_data)) stab_err <= stab_err + 1;
      if (rom_inc) begin
        if (inc_n < 64) inc_cyc[inc_n] <= cyc_n;
        inc_n <= inc_n + 1;
      end
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (done || error) break;
    end
  endtask

  // One full pass of the list, checked against the hand-derived expectations.
  task automatic run_list(input string tag, input int hold_cycles, input bit poke_busy);
    int bw;
    int bi;
    bw = wr_n;
    bi = inc_n;
    if (hold_cycles > 0) hold = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (hold_cycles > 0) begin
      repeat (hold_cycles) @(negedge clk);
      check({tag, "_hold_nowr"}, wr_n - bw, 32'd0);
      check({tag, "_hold_nostart"}, {31'd0, sccb_start}, 32'd0);
      hold = 1'b0;
    end
    if (poke_busy) begin
      repeat (18) @(negedge clk);
      check({tag, "_poke_busy"}, {31'd0, busy}, 32'd1);
      pulse_start();
    end
    wait_end(400);
    repeat (2) @(negedge clk);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, error}, 32'd0);
    check({tag, "_nwr"}, wr_n - bw, 32'd2);
    check({tag, "_wr0"}, {8'd0, wr_log[bw]}, 32'h421280);
    check({tag, "_wr1"}, {8'd0, wr_log[bw+1]}, 32'h421204);
    check({tag, "_ninc"}, inc_n - bi, 32'd3);
    // advance(1) + rom_wait(2) + fetch(1) + delay(10)
    check({tag, "_delay_gap"}, inc_cyc[bi+1] - inc_cyc[bi], 32'd14);
    check({tag, "_stable"}, stab_err, 32'd0);
    check({tag, "_proto"}, proto_err, 32'd0);
    check({tag, "_rom_over"}, rom_over, 32'd0);
  endtask

  initial begin
    int bw;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {10'd0, busy, done, error, rom_inc, sccb_start, sccb_addr, sccb_data,
                       rom_rst_n}, 32'd0);
    check("rst_id", {24'd0, sccb_id}, 32'h42);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_list("basic", 0, 1'b1);
    run_list("rerun", 0, 1'b0);
    run_list("hold", 50, 1'b0);

    // Reset in the fifth DELAY cycle, then replay from entry 0.
    bw = wr_n;
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rom_inc) break;
    end
    check("mid_inc_seen", {31'd0, rom_inc}, 32'd1);
    repeat (8) @(posedge clk);
    check("mid_in_delay", {30'd0, busy, sccb_start}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outs", {10'd0, busy, done, error, rom_inc, sccb_start, sccb_addr, sccb_data,
                           rom_rst_n}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_nwr", wr_n - bw, 32'd1);
    run_list("replay", 0, 1'b0);

    // Acknowledge that never arrives.
    ack_lat = 1000;
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      if (sccb_start) break;
      @(negedge clk);
    end
    check("to_start_seen", {31'd0, sccb_start}, 32'd1);
`ifdef OV7670_SEQ_TIMEOUT_EN
    repeat (99) @(negedge clk);
    check("to_before", {31'd0, error}, 32'd0);
    @(negedge clk);
    check("to_error", {31'd0, error}, 32'd1);
    check("to_done", {31'd0, done}, 32'd0);
    check("to_idle", {31'd0, busy}, 32'd0);
`else
    repeat (150) @(negedge clk);
    check("stuck_busy", {31'd0, busy}, 32'd1);
    check("stuck_err", {31'd0, error}, 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ack_lat = 3;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
